// File: rtl/trace_pkg.sv
// Shared types for the commit-trace monitor: event kinds, the buffered
// trace record and the monitor run state.
package trace_pkg;

    localparam int TRACE_XLEN  = 32;
    localparam int TRACE_CNT_W = 32;

    typedef enum logic [1:0] {
        REG   = 2'd0,
        CSR   = 2'd1,
        STORE = 2'd2,
        RSVD  = 2'd3
    } evt_kind_t;

    // "time" is a keyword, so the timestamp field is called stamp
    typedef struct packed {
        evt_kind_t               kind;
        logic [TRACE_XLEN-1:0]   pc;
        logic [TRACE_XLEN-1:0]   addr;
        logic [TRACE_XLEN-1:0]   data;
        logic [3:0]              strb;
        logic [TRACE_CNT_W-1:0]  stamp;
    } trace_rec_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } mon_state_t;

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through buffer of trace records. Pointers carry an extra
// wrap bit so full and empty are distinguishable without a counter.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  trace_rec_t push_rec,
    input  logic       pop,
    output trace_rec_t head,
    output logic       empty,
    output logic       full,
    output logic       one_left
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    trace_rec_t mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        wr_en;
    logic        rd_en;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign one_left = ((wr_ptr - rd_ptr) == PTR_ONE);

    // A full buffer still takes a write when the head leaves in the same cycle
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_rec;
    end

endmodule

// File: rtl/trace_monitor.sv
// Commit-trace and host-termination monitor: filters commit events into a
// timestamped FIFO, then drains it and halts on a host write or timeout.
module trace_monitor
    import trace_pkg::*;
#(
    parameter int XLEN  = TRACE_XLEN,
    parameter int DEPTH = 16,
    parameter int NHOST = 2,
    parameter int CNT_W = TRACE_CNT_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    evt_valid,
    input  logic [1:0]              evt_kind,
    input  logic [XLEN-1:0]         evt_pc,
    input  logic [XLEN-1:0]         evt_addr,
    input  logic [XLEN-1:0]         evt_data,
    input  logic [3:0]              evt_strb,
    input  logic [2:0]              kind_en,
    input  logic [CNT_W-1:0]        max_cycles,
    input  logic [NHOST*XLEN-1:0]   host_addr,
    input  logic                    mem_valid,
    input  logic [XLEN-1:0]         mem_addr,
    input  logic [3:0]              mem_wstrb,
    input  logic [XLEN-1:0]         mem_wdata,
    output logic                    trc_valid,
    input  logic                    trc_ready,
    output logic [1:0]              trc_kind,
    output logic [XLEN-1:0]         trc_pc,
    output logic [XLEN-1:0]         trc_addr,
    output logic [XLEN-1:0]         trc_data,
    output logic [3:0]              trc_strb,
    output logic [CNT_W-1:0]        trc_time,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic                    halt,
    output logic [$clog2(NHOST):0]  halt_chan,
    output logic [XLEN-1:0]         exit_code
);

    localparam int HCW = $clog2(NHOST) + 1;
    localparam logic [HCW-1:0]   TIMEOUT_CHAN = NHOST[HCW-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  WORD_MASK    = {{(XLEN-2){1'b1}}, 2'b00};

    mon_state_t       state_q;
    mon_state_t       state_d;
    logic [CNT_W-1:0] cycle_q;
    logic [3:0]       kind_en_ext;
    logic             accept;
    logic             push;
    logic             pop;
    logic             drop;
    logic             timeout;
    logic             host_hit;
    logic [HCW-1:0]   hit_idx;
    trace_rec_t       new_rec;
    trace_rec_t       head;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_one_left;

    // Kind 3 maps to a permanently clear enable bit
    assign kind_en_ext = {1'b0, kind_en};

    assign accept = evt_valid && kind_en_ext[evt_kind] && (state_q == RUN)
                    && !((evt_kind == 2'd2) && (evt_strb == 4'd0));
    assign pop    = !fifo_empty && trc_ready;
    assign push   = accept && (!fifo_full || pop);
    assign drop   = accept && fifo_full && !pop;

    assign timeout = (state_q == RUN) && (max_cycles != '0) && (cycle_q == max_cycles);

    assign new_rec = '{kind:  evt_kind_t'(evt_kind),
                       pc:    evt_pc,
                       addr:  evt_addr,
                       data:  evt_data,
                       strb:  evt_strb,
                       stamp: cycle_q};

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_rec (new_rec),
        .pop      (pop),
        .head     (head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .one_left (fifo_one_left)
    );

    // Walk channels downward so the lowest matching index is the one kept
    always_comb begin
        host_hit = 1'b0;
        hit_idx  = '0;
        for (int i = NHOST - 1; i >= 0; i--) begin
            if (mem_valid && (mem_wstrb != 4'd0)
                && ((mem_addr & WORD_MASK) == (host_addr[i*XLEN +: XLEN] & WORD_MASK))) begin
                host_hit = 1'b1;
                hit_idx  = i[HCW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (host_hit || timeout) state_d = DRAIN;
            DRAIN:   if (fifo_empty || (fifo_one_left && pop)) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            cycle_q   <= '0;
            drop_cnt  <= '0;
            halt_chan <= '0;
            exit_code <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != HALTED) cycle_q <= cycle_q + CNT_ONE;
            if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_ONE;
            if ((state_q == RUN) && host_hit) begin
                halt_chan <= hit_idx;
                exit_code <= mem_wdata;
            end else if ((state_q == RUN) && timeout) begin
                halt_chan <= TIMEOUT_CHAN;
                exit_code <= '0;
            end
        end
    end

    assign halt      = (state_q == HALTED);
    assign trc_valid = !fifo_empty;
    assign trc_kind  = head.kind;
    assign trc_pc    = head.pc;
    assign trc_addr  = head.addr;
    assign trc_data  = head.data;
    assign trc_strb  = head.strb;
    assign trc_time  = head.stamp;

endmodule

// File: tb/tb_trace_monitor.sv
// Bench for trace_monitor: directed scenarios plus randomized rounds, all
// checked against a queue-based reference model of the monitor.
module tb_trace_monitor;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int NHOST = 2;
    localparam int CNT_W = 32;

    logic                  clock;
    logic                  reset;
    logic                  evt_valid;
    logic [1:0]            evt_kind;
    logic [XLEN-1:0]       evt_pc;
    logic [XLEN-1:0]       evt_addr;
    logic [XLEN-1:0]       evt_data;
    logic [3:0]            evt_strb;
    logic [2:0]            kind_en;
    logic [CNT_W-1:0]      max_cycles;
    logic [NHOST*XLEN-1:0] host_addr;
    logic                  mem_valid;
    logic [XLEN-1:0]       mem_addr;
    logic [3:0]            mem_wstrb;
    logic [XLEN-1:0]       mem_wdata;
    logic                  trc_valid;
    logic                  trc_ready;
    logic [1:0]            trc_kind;
    logic [XLEN-1:0]       trc_pc;
    logic [XLEN-1:0]       trc_addr;
    logic [XLEN-1:0]       trc_data;
    logic [3:0]            trc_strb;
    logic [CNT_W-1:0]      trc_time;
    logic [CNT_W-1:0]      drop_cnt;
    logic                  halt;
    logic [1:0]            halt_chan;
    logic [XLEN-1:0]       exit_code;

    trace_monitor #(.XLEN(XLEN), .DEPTH(DEPTH), .NHOST(NHOST), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .evt_valid(evt_valid), .evt_kind(evt_kind), .evt_pc(evt_pc),
        .evt_addr(evt_addr), .evt_data(evt_data), .evt_strb(evt_strb),
        .kind_en(kind_en), .max_cycles(max_cycles), .host_addr(host_addr),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata),
        .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_kind(trc_kind),
        .trc_pc(trc_pc), .trc_addr(trc_addr), .trc_data(trc_data),
        .trc_strb(trc_strb), .trc_time(trc_time), .drop_cnt(drop_cnt),
        .halt(halt), .halt_chan(halt_chan), .exit_code(exit_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]       kind;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  data;
        logic [3:0]       strb;
        logic [CNT_W-1:0] stamp;
    } rec_t;

    rec_t             mq[$];
    logic [CNT_W-1:0] m_cycle;
    logic [CNT_W-1:0] m_drop;
    logic [XLEN-1:0]  m_exit;
    logic [1:0]       m_chan;
    bit               m_run;
    bit               m_drain;
    bit               m_halt;
    int               checks = 0;
    int               errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        m_cycle = '0;
        m_drop  = '0;
        m_exit  = '0;
        m_chan  = '0;
        m_run   = 1'b1;
        m_drain = 1'b0;
        m_halt  = 1'b0;
    endtask

    // One clock of the reference model, evaluated on the inputs seen at the edge
    task automatic modelEdge();
        int   sz       = mq.size();
        bit   was_halt = m_halt;
        bit   do_pop   = (sz > 0) && trc_ready;
        int   hit      = -1;
        int   k        = evt_kind;
        bit   tmo;
        bit   acc;
        rec_t r;
        if (mem_valid && (mem_wstrb != 0))
            for (int i = 0; i < NHOST; i++)
                if (hit < 0 && mem_addr[XLEN-1:2] == host_addr[i*XLEN+2 +: XLEN-2]) hit = i;
        tmo = m_run && (max_cycles != 0) && (m_cycle == max_cycles);
        acc = m_run && evt_valid && (k < 3) && kind_en[k] && !(k == 2 && evt_strb == 0);
        if (do_pop) void'(mq.pop_front());
        if (acc) begin
            if (sz == DEPTH && !do_pop) begin
                if (m_drop != '1) m_drop = m_drop + 1;
            end else begin
                r.kind = evt_kind; r.pc = evt_pc; r.addr = evt_addr;
                r.data = evt_data; r.strb = evt_strb; r.stamp = m_cycle;
                mq.push_back(r);
            end
        end
        if (m_run && (hit >= 0 || tmo)) begin
            m_run   = 1'b0;
            m_drain = 1'b1;
            if (hit >= 0) begin
                m_chan = hit[1:0];
                m_exit = mem_wdata;
            end else begin
                m_chan = NHOST[1:0];
                m_exit = '0;
            end
        end else if (m_drain && mq.size() == 0) begin
            m_drain = 1'b0;
            m_halt  = 1'b1;
        end
        if (!was_halt) m_cycle = m_cycle + 1;
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".valid"}, trc_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk({tag, ".kind"}, trc_kind, mq[0].kind);
            chk({tag, ".pc"},   trc_pc,   mq[0].pc);
            chk({tag, ".addr"}, trc_addr, mq[0].addr);
            chk({tag, ".data"}, trc_data, mq[0].data);
            chk({tag, ".strb"}, trc_strb, mq[0].strb);
            chk({tag, ".time"}, trc_time, mq[0].stamp);
        end
        chk({tag, ".drop"}, drop_cnt,  m_drop);
        chk({tag, ".halt"}, halt,      m_halt);
        chk({tag, ".chan"}, halt_chan, m_chan);
        chk({tag, ".exit"}, exit_code, m_exit);
    endtask

    task automatic checkResetState(input string tag);
        chk({tag, ".valid"}, trc_valid, 0);
        chk({tag, ".kind"},  trc_kind,  0);
        chk({tag, ".pc"},    trc_pc,    0);
        chk({tag, ".addr"},  trc_addr,  0);
        chk({tag, ".data"},  trc_data,  0);
        chk({tag, ".strb"},  trc_strb,  0);
        chk({tag, ".time"},  trc_time,  0);
        chk({tag, ".drop"},  drop_cnt,  0);
        chk({tag, ".halt"},  halt,      0);
        chk({tag, ".chan"},  halt_chan, 0);
        chk({tag, ".exit"},  exit_code, 0);
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        modelEdge();
        #1;
        checkOutput(tag);
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] kind, input logic [31:0] pc,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb);
        evt_valid = v; evt_kind = kind; evt_pc = pc;
        evt_addr = addr; evt_data = data; evt_strb = strb;
    endtask

    task automatic setMem(input logic v, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] data);
        mem_valid = v; mem_addr = addr; mem_wstrb = strb; mem_wdata = data;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 2'd0, '0, '0, '0, 4'd0);
        setMem(1'b0, '0, 4'd0, '0);
    endtask

    // Called between edges: asserts reset asynchronously and checks at once
    task automatic doReset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        checkResetState(tag);
        modelReset();
        #2;
        reset = 1'b1;
    endtask

    task automatic randomCycle(input string tag);
        logic [XLEN-1:0] ha;
        int              sel;
        applyStimulus($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), $urandom, $urandom,
                      $urandom, ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom));
        trc_ready = $urandom_range(0, 2) != 0;
        if ($urandom_range(0, 15) == 0) kind_en = 3'($urandom);
        sel = $urandom_range(0, NHOST - 1);
        ha  = host_addr[sel*XLEN +: XLEN];
        if ($urandom_range(0, 19) == 0)
            setMem(1'b1, {ha[31:2], 2'($urandom_range(0, 3))},
                   ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom), $urandom);
        else
            setMem($urandom_range(0, 3) == 0, $urandom, 4'($urandom), $urandom);
        step(tag);
    endtask

    initial begin
        int n;
        reset      = 1'b0;
        kind_en    = 3'b111;
        trc_ready  = 1'b1;
        max_cycles = '0;
        host_addr  = {32'h0000_2000, 32'h0000_1000};
        idle();
        #12;
        checkResetState("reset");
        modelReset();
        reset = 1'b1;

        // Basic record: timestamp equals the counter in the accept cycle
        for (int i = 0; i < 30 && m_cycle != 20; i++) step("t1_wait");
        applyStimulus(1'b1, 2'd0, 32'h8000_0000, 32'd5, 32'hDEAD_BEEF, 4'd0);
        step("t1");
        chk("t1_valid", trc_valid, 1);
        chk("t1_kind",  trc_kind,  0);
        chk("t1_data",  trc_data,  32'hDEAD_BEEF);
        chk("t1_time",  trc_time,  20);
        idle();
        step("t1_pop");

        // Filtering: zero-strobe stores and disabled kinds
        applyStimulus(1'b1, 2'd2, 32'h100, 32'h400, 32'h11, 4'b0000);
        step("t2_s0");
        chk("t2_zero_strb", trc_valid, 0);
        applyStimulus(1'b1, 2'd2, 32'h104, 32'h404, 32'h22, 4'b0011);
        step("t2_s3");
        chk("t2_store_kind", trc_kind, 2);
        chk("t2_store_strb", trc_strb, 4'b0011);
        kind_en = 3'b011;
        applyStimulus(1'b1, 2'd2, 32'h108, 32'h408, 32'h33, 4'b0011);
        step("t2_dis");
        chk("t2_store_disabled", trc_valid, 0);
        applyStimulus(1'b1, 2'd1, 32'h10c, 32'h300, 32'h44, 4'd0);
        step("t2_csr");
        chk("t2_csr_kind", trc_kind, 1);
        kind_en = 3'b111;
        idle();
        step("t2_idle");

        // Overflow: 20 events into 16 slots, then a push/pop on a full buffer
        trc_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 2'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 4'd0);
            step("t3_fill");
        end
        chk("t3_drop", drop_cnt, 4);
        trc_ready = 1'b1;
        applyStimulus(1'b1, 2'd0, 32'hAAAA, 32'h1, 32'hBBBB, 4'd0);
        step("t3_pushpop");
        chk("t3_drop_kept", drop_cnt, 4);
        idle();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (trc_valid) n++;
            step("t3_drain");
        end
        chk("t3_count", n, 16);

        // Host termination on channel 1 with buffered records held back
        setMem(1'b1, 32'h1002, 4'b0000, 32'h99);
        step("t4_nostrb");
        chk("t4_nostrb_halt", halt, 0);
        setMem(1'b0, '0, 4'd0, '0);
        trc_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 2'd0, 32'h200 + i, 32'd3, 32'h500 + i, 4'd0);
            step("t4_fill");
        end
        applyStimulus(1'b1, 2'd1, 32'h300, 32'd7, 32'h600, 4'd0);
        setMem(1'b1, 32'h2000, 4'b1111, 32'd1);
        step("t4_hit");
        applyStimulus(1'b1, 2'd0, 32'h400, 32'd9, 32'h700, 4'd0);
        setMem(1'b1, 32'h1000, 4'b1111, 32'd9);
        step("t4_ignored");
        idle();
        for (int i = 0; i < 3; i++) step("t4_hold");
        chk("t4_hold_halt", halt, 0);
        trc_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (trc_valid) n++;
            step("t4_drain");
        end
        chk("t4_pops", n, 3);
        chk("t4_halt", halt, 1);
        chk("t4_chan", halt_chan, 1);
        chk("t4_exit", exit_code, 1);

        // Timeout, then timeout coinciding with a channel-0 write
        doReset("t5_reset");
        max_cycles = 32'd50;
        for (int i = 0; i < 60; i++) step("t5_run");
        chk("t5_halt", halt, 1);
        chk("t5_chan", halt_chan, NHOST);
        chk("t5_exit", exit_code, 0);
        doReset("t5b_reset");
        max_cycles = 32'd30;
        for (int i = 0; i < 40 && m_cycle != 30; i++) step("t5b_wait");
        setMem(1'b1, 32'h1000, 4'b0001, 32'h55);
        step("t5b_both");
        idle();
        for (int i = 0; i < 3; i++) step("t5b_end");
        chk("t5b_halt", halt, 1);
        chk("t5b_chan", halt_chan, 0);
        chk("t5b_exit", exit_code, 32'h55);

        // Reset while draining loses everything and restarts the counter
        doReset("t6_pre");
        max_cycles = '0;
        trc_ready  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 2'd0, 32'h900 + i, 32'd1, 32'h800 + i, 4'd0);
            step("t6_fill");
        end
        idle();
        setMem(1'b1, 32'h2000, 4'b0100, 32'h77);
        step("t6_hit");
        idle();
        step("t6_drain");
        doReset("t6_mid");
        trc_ready = 1'b1;
        applyStimulus(1'b1, 2'd0, 32'hC00, 32'd2, 32'hC0DE, 4'd0);
        step("t6_after");
        chk("t6_time", trc_time, 0);
        chk("t6_valid", trc_valid, 1);
        idle();

        // Randomized rounds; round 2 aliases both channels to test priority
        for (int r = 0; r < 4; r++) begin
            doReset("rnd_reset");
            kind_en    = 3'($urandom);
            max_cycles = (r % 2 == 1) ? 32'($urandom_range(100, 300)) : '0;
            host_addr  = (r == 2) ? {32'h0000_3000, 32'h0000_3000}
                                  : {32'($urandom) & 32'hFFFF_FFFC, 32'($urandom)};
            for (int i = 0; i < 300; i++) randomCycle("rnd");
        end

        $display("[TB] directed and random phases done");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
